run_sequencer: RTL and testbench
================================

# run_sequencer

Multi-cycle control sequencer for the 9-bit-instruction core. It sits between the fetch/decode path (instruction ROM output and Control decoder strobes) and the state-holding elements: PC, instruction latch, register file write port, data memory write port, and the flag/carry registers. It converts single-cycle decode strobes into a FETCH/EXEC/MEM/WB schedule. It also runs a level req/done handshake with the test harness, detects the halt word, and enforces a cycle-budget timeout. It replaces the free-running `prog_ctr > N` done heuristic.

## Interface
Parameters:
- D, 12, program counter width (passed through; sizes nothing internal except documentation of pc_en use)
- CW, 16, width of cycle and instruction counters
- TMAX, 4000, cycle budget; reaching it ends the run with timeout

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; one clock; clears all state
- req  in  1  level run request from harness
- mach_code  in  9  current ROM word at PC (combinational)
- reg_write  in  1  Control RegWrite for current instruction
- mem_write  in  1  Control MemWrite
- mem_to_reg  in  1  Control MemtoReg (load)
- pc_clr  out  1  force PC to 0
- pc_en  out  1  advance/jump PC this edge
- ir_ld  out  1  latch mach_code into instruction register
- rf_we  out  1  gated register-file write enable
- mem_we  out  1  gated data-memory write enable
- flag_en  out  1  load pariQ/zeroQ/sc registers
- done  out  1  run complete, held until req drops
- timeout  out  1  run ended by budget, valid while done=1
- cyc_cnt  out  CW  cycles spent in FETCH..WB this run
- instr_cnt  out  CW  instructions retired (WB count) this run

## Operation
- States: IDLE, INIT, FETCH, EXEC, MEM, WB, DONE.
- IDLE: all strobes 0. req=1 -> INIT.
- INIT: pc_clr=1. Clears cyc_cnt, instr_cnt, timeout. -> FETCH.
- FETCH:
  - If mach_code == 9'h1FF (HALT), -> DONE with no ir_ld.
  - Otherwise ir_ld=1, -> EXEC.
- EXEC:
  - flag_en=1.
  - mem_write|mem_to_reg -> MEM; else -> WB.
- MEM: mem_we = mem_write, a single-cycle pulse. -> WB.
- WB:
  - rf_we = reg_write, pc_en=1, instr_cnt++.
  - -> FETCH.
- DONE: done=1. Stays while req=1. req=0 -> IDLE.
- Timeout: in FETCH/EXEC/MEM/WB, if cyc_cnt == TMAX-1, next state is DONE with timeout=1. This overrides the normal transition, and no strobes fire that cycle except those already combinationally decoded for the current state.
- Counters:
  - cyc_cnt increments in FETCH/EXEC/MEM/WB, saturates at all-ones.
  - instr_cnt increments in WB, saturates.
  - Both hold in IDLE/DONE.
- req falling during a run: ignored; run completes to DONE, then exits to IDLE next cycle.
- Strobes are Moore outputs of state, gated only by the listed decode inputs. No strobe is asserted in IDLE, INIT (except pc_clr) or DONE.

## Timing
- Reset (reset=0 at an edge): state=IDLE; all outputs 0; counters 0. A reset mid-run aborts immediately; a pending mem_we/rf_we does not fire on that edge.
- Latency req->first ir_ld: 2 cycles (INIT, then FETCH).
- Instruction cost: 3 cycles (ALU/branch), 4 cycles (load/store).
- done rises on the edge entering DONE and falls 1 cycle after req=0 is sampled.
- Simultaneous HALT and timeout in FETCH: go to DONE with timeout=1.

## Structure
- Package seq_pkg holds:
  - state_t enum (7 states, 3-bit)
  - HALT_WORD = 9'h1FF
  - default CW/TMAX constants
- Sub-module sat_counter #(W), with ports clk, reset, clr, inc and cnt. It is instantiated twice, for cyc_cnt and instr_cnt.
- The top-level integration drives:
  - the PC's reset and enable from pc_clr/pc_en
  - the reg_file wr_en from rf_we
  - the dat_mem wr_en from mem_we
  - the flag register enables from flag_en

## Test plan
- Reset held low 2 cycles with req=1 -> IDLE, every output 0, counters 0; released -> INIT next cycle, pc_clr=1.
- ROM {ALU op with reg_write=1, 9'h1FF}, req=1 at cycle 0 -> INIT c1, FETCH c2 (ir_ld), EXEC c3 (flag_en), WB c4 (rf_we=1, pc_en=1), FETCH c5 sees HALT, done=1 at c6; instr_cnt=1, cyc_cnt=4, timeout=0.
- Store (mem_write=1, reg_write=0) then HALT -> mem_we high exactly one cycle (MEM state), rf_we=0 in WB, 4 cycles for the instruction; instr_cnt=1, cyc_cnt=5.
- TMAX=10, program is a branch-to-self loop -> done=1, timeout=1 after cyc_cnt reaches 9; instr_cnt=3.
- Handshake: after done, hold req 5 cycles -> done stays 1, counters stable; drop req -> done=0 next cycle; raise req -> INIT, counters cleared to 0.
- Reset asserted while in MEM with mem_write=1 -> mem_we=0 on that edge, state IDLE next cycle, no instr_cnt increment.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and constants for the run sequencer
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [8:0] HALT_WORD = 9'h1FF;
    localparam int         DEF_CW    = 16;
    localparam int         DEF_TMAX  = 4000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - FETCH/EXEC/MEM/WB scheduler with run handshake, halt detect and cycle budget
module run_sequencer
    import seq_pkg::*;
#(
    parameter int D    = 12,
    parameter int CW   = DEF_CW,
    parameter int TMAX = DEF_TMAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [8:0]    mach_code,
    input  logic          reg_write,
    input  logic          mem_write,
    input  logic          mem_to_reg,
    output logic          pc_clr,
    output logic          pc_en,
    output logic          ir_ld,
    output logic          rf_we,
    output logic          mem_we,
    output logic          flag_en,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cyc_cnt,
    output logic [CW-1:0] instr_cnt
);

    state_t state_q;
    state_t state_d;
    logic   timeout_q;
    logic   timeout_d;
    logic   run_st;
    logic   budget_hit;

    // The PC width only matters to the PC itself; this block just strobes it.
    logic   unused_pc_w;
    assign unused_pc_w = (D > 0);

    assign run_st     = state_q inside {S_FETCH, S_EXEC, S_MEM, S_WB};
    assign budget_hit = run_st && (cyc_cnt == CW'(TMAX - 1));

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        pc_clr    = 1'b0;
        pc_en     = 1'b0;
        ir_ld     = 1'b0;
        rf_we     = 1'b0;
        mem_we    = 1'b0;
        flag_en   = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) state_d = S_INIT;
            end
            S_INIT: begin
                pc_clr    = 1'b1;
                timeout_d = 1'b0;
                state_d   = S_FETCH;
            end
            S_FETCH: begin
                if (mach_code == HALT_WORD) begin
                    state_d = S_DONE;
                end else begin
                    ir_ld   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                flag_en = 1'b1;
                state_d = (mem_write || mem_to_reg) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_we  = mem_write;
                state_d = S_WB;
            end
            S_WB: begin
                rf_we   = reg_write;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            S_DONE: begin
                done = 1'b1;
                if (!req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Budget exhaustion wins over halt and the normal schedule.
        if (budget_hit) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
        end

        // A reset cycle must not let any write strobe reach the datapath.
        if (!reset) begin
            pc_clr  = 1'b0;
            pc_en   = 1'b0;
            ir_ld   = 1'b0;
            rf_we   = 1'b0;
            mem_we  = 1'b0;
            flag_en = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

    sat_counter #(.W(CW)) u_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == S_INIT),
        .inc   (run_st),
        .cnt   (cyc_cnt)
    );

    sat_counter #(.W(CW)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == S_INIT),
        .inc   (state_q == S_WB),
        .cnt   (instr_cnt)
    );

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - scoreboard bench for run_sequencer driven by a small ROM/PC model
module tb_run_sequencer;

    localparam int CW   = 16;
    localparam int TMAX = 10;

    // strobe vector order: {pc_clr, pc_en, ir_ld, rf_we, mem_we, flag_en, done}
    localparam logic [6:0] CLR = 7'b1000000;
    localparam logic [6:0] PCE = 7'b0100000;
    localparam logic [6:0] IRL = 7'b0010000;
    localparam logic [6:0] RFW = 7'b0001000;
    localparam logic [6:0] MEW = 7'b0000100;
    localparam logic [6:0] FLG = 7'b0000010;
    localparam logic [6:0] DN  = 7'b0000001;

    typedef struct {
        int          cyc;
        logic [6:0]  strb;
        logic        tmo;
        logic [CW-1:0] cc;
        logic [CW-1:0] ic;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic [8:0]    mach_code;
    logic          reg_write, mem_write, mem_to_reg;
    logic          pc_clr, pc_en, ir_ld, rf_we, mem_we, flag_en, done, timeout;
    logic [CW-1:0] cyc_cnt, instr_cnt;

    always #5 clk = ~clk;

    run_sequencer #(.D(12), .CW(CW), .TMAX(TMAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .mach_code  (mach_code),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .pc_clr     (pc_clr),
        .pc_en      (pc_en),
        .ir_ld      (ir_ld),
        .rf_we      (rf_we),
        .mem_we     (mem_we),
        .flag_en    (flag_en),
        .done       (done),
        .timeout    (timeout),
        .cyc_cnt    (cyc_cnt),
        .instr_cnt  (instr_cnt)
    );

    logic [8:0] rom    [0:3];
    logic       rom_rw [0:3];
    logic       rom_mw [0:3];
    logic       rom_mr [0:3];
    logic       rom_br [0:3];
    logic [1:0] pc = 2'd0;

    always @(posedge clk) begin
        if (pc_clr) pc <= 2'd0;
        else if (pc_en && !rom_br[pc]) pc <= pc + 2'd1;
    end

    assign mach_code  = rom[pc];
    assign reg_write  = rom_rw[pc];
    assign mem_write  = rom_mw[pc];
    assign mem_to_reg = rom_mr[pc];

    int   cyc_no = 0;
    logic done_d = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    always @(posedge clk) begin
        cyc_no <= cyc_no + 1;
        done_d <= done;
    end

    always @(negedge clk) begin : monitor
        logic [6:0] s;
        exp_t       e;
        s = {pc_clr, pc_en, ir_ld, rf_we, mem_we, flag_en, done};
        if ((s[6:1] != 6'd0) || (done && !done_d)) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output cyc=%0d strb=%b required no output", cyc_no, s);
            end else begin
                e = sb_q.pop_front();
                if ((e.cyc != cyc_no) || (e.strb != s) ||
                    (e.strb[0] && ({e.tmo, e.cc, e.ic} != {timeout, cyc_cnt, instr_cnt}))) begin
                    n_fail++;
                    $display("FAIL strobe_trace got cyc=%0d strb=%b tmo=%b cc=%0d ic=%0d required cyc=%0d strb=%b tmo=%b cc=%0d ic=%0d",
                             cyc_no, s, timeout, cyc_cnt, instr_cnt, e.cyc, e.strb, e.tmo, e.cc, e.ic);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h", name, got, expv);
        end
    endtask

    task automatic push(input int c, input logic [6:0] s, input logic t = 1'b0,
                        input int cc = 0, input int ic = 0);
        exp_t e;
        e.cyc  = c;
        e.strb = s;
        e.tmo  = t;
        e.cc   = CW'(cc);
        e.ic   = CW'(ic);
        sb_q.push_back(e);
    endtask

    task automatic set_prog(input int p);
        for (int i = 0; i < 4; i++) begin
            rom[i] = 9'h1FF; rom_rw[i] = 1'b0; rom_mw[i] = 1'b0; rom_mr[i] = 1'b0; rom_br[i] = 1'b0;
        end
        case (p)
            0: begin rom[0] = 9'h021; rom_rw[0] = 1'b1; end
            1: begin rom[0] = 9'h080; rom_mw[0] = 1'b1; end
            2: begin
                rom[0] = 9'h050; rom_rw[0] = 1'b1; rom_mr[0] = 1'b1;
                rom[1] = 9'h021; rom_rw[1] = 1'b1;
            end
            default: begin rom[0] = 9'h0C0; rom_br[0] = 1'b1; end
        endcase
    endtask

    task automatic exp_alu(input int b);
        push(b + 1, CLR); push(b + 2, IRL); push(b + 3, FLG); push(b + 4, PCE | RFW);
        push(b + 6, DN, 1'b0, 4, 1);
    endtask

    task automatic exp_store(input int b);
        push(b + 1, CLR); push(b + 2, IRL); push(b + 3, FLG); push(b + 4, MEW); push(b + 5, PCE);
        push(b + 7, DN, 1'b0, 5, 1);
    endtask

    task automatic exp_load_alu(input int b);
        push(b + 1, CLR); push(b + 2, IRL); push(b + 3, FLG); push(b + 5, PCE | RFW);
        push(b + 6, IRL); push(b + 7, FLG); push(b + 8, PCE | RFW);
        push(b + 10, DN, 1'b0, 8, 2);
    endtask

    task automatic exp_loop(input int b);
        push(b + 1, CLR);
        for (int i = 0; i < 3; i++) begin
            push(b + 2 + 3 * i, IRL); push(b + 3 + 3 * i, FLG); push(b + 4 + 3 * i, PCE);
        end
        push(b + 11, IRL);
        push(b + 12, DN, 1'b1, 10, 3);
    endtask

    task automatic run_start(output int base);
        @(posedge clk); #1;
        req  = 1'b1;
        base = cyc_no;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while ((done !== 1'b1) && (k < 40)) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    task automatic end_run();
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog expired got=running required=finished");
        $fatal(1);
    end

    initial begin : stim
        int b;
        reset = 1'b0;
        req   = 1'b1;
        set_prog(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({pc_clr, pc_en, ir_ld, rf_we, mem_we, flag_en, done, timeout}), 64'd0);
        check("reset_counters", 64'({cyc_cnt, instr_cnt}), 64'd0);

        // release with req already high: INIT on the next edge
        @(posedge clk); #1;
        reset = 1'b1;
        b = cyc_no;
        exp_alu(b);
        wait_done("alu_done");

        repeat (5) begin
            @(negedge clk);
            check("hold_done", 64'({done, cyc_cnt, instr_cnt}), 64'({1'b1, 16'd4, 16'd1}));
        end
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("done_before_req_sampled", 64'(done), 64'd1);
        @(negedge clk);
        check("done_after_req_low", 64'(done), 64'd0);

        @(posedge clk); #1;
        req = 1'b1;
        b = cyc_no;
        exp_alu(b);
        while (cyc_no < b + 2) @(negedge clk);
        check("counters_cleared", 64'({cyc_cnt, instr_cnt, timeout}), 64'd0);
        wait_done("alu_rerun_done");
        end_run();

        set_prog(1);
        run_start(b);
        exp_store(b);
        wait_done("store_done");
        end_run();

        set_prog(2);
        run_start(b);
        exp_load_alu(b);
        wait_done("load_alu_done");
        end_run();

        set_prog(3);
        run_start(b);
        exp_loop(b);
        wait_done("loop_done");
        check("loop_timeout", 64'(timeout), 64'd1);
        end_run();

        // abort a store while it sits in MEM
        set_prog(1);
        run_start(b);
        push(b + 1, CLR); push(b + 2, IRL); push(b + 3, FLG);
        while (cyc_no < b + 4) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk);
        check("mem_we_on_reset_edge", 64'({mem_we, rf_we, pc_en, done}), 64'd0);
        @(posedge clk); #1;
        req   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_abort", 64'({pc_clr, pc_en, ir_ld, rf_we, mem_we, flag_en, done}), 64'd0);
        check("counters_after_abort", 64'({cyc_cnt, instr_cnt, timeout}), 64'd0);
        repeat (2) @(negedge clk);
        check("still_idle", 64'({pc_clr, ir_ld, done, cyc_cnt}), 64'd0);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
